axi_data_wr_top: RTL and testbench
==================================

AXI_DATA_WR_TOP -- requirements
Module: axi_data_wr_top

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width of all address ports.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 512, data width; BPB = AXI_DATA_WIDTH/8 bytes per beat.
REQ-003 SHALL have parameter AXI_XFER_SIZE_WIDTH, default 32, width of the byte-count input.
REQ-004 SHALL have parameter BURST_BEATS, default 16, maximum beats per AW burst (1..256).
REQ-005 SHALL have parameter BRAM_DELAY, default 1, BRAM read latency in cycles.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- axi_awvalid / axi_awready  out / in  1 / 1  AW handshake
- axi_awaddr  out  AXI_ADDR_WIDTH  burst address
- axi_awlen  out  8  beats-1
- axi_wvalid / axi_wready  out / in  1 / 1  W handshake
- axi_wdata  out  AXI_DATA_WIDTH  write data
- axi_wlast  out  1  last beat of burst
- axi_bvalid / axi_bready  in / out  1 / 1  B handshake
- i_axi_wr_command  in  32  0 = BRAM source, 1 = stream source
- i_axi_wr_start  in  1  start pulse
- o_axi_wr_done  out  1  high when idle
- i_axi_wr_base_addr  in  AXI_ADDR_WIDTH  BRAM start word address
- data_ptr  in  AXI_ADDR_WIDTH  AXI destination byte address
- data_size_bytes  in  AXI_XFER_SIZE_WIDTH  transfer length in bytes
- bram_rd_en  out  1  BRAM read strobe
- bram_rd_addr  out  AXI_ADDR_WIDTH  BRAM word address
- bram_rd_data  in  AXI_DATA_WIDTH  BRAM data, valid BRAM_DELAY cycles after bram_rd_en
- s_axis_tdata  in  AXI_DATA_WIDTH  decoder stream data
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  stream handshake
- s_axis_tlast  in  1  informational only; ignored

Function
REQ-007 SHALL implement FSM IDLE, ADDR, DATA, RESP; o_axi_wr_done = (state == IDLE).
REQ-008 In IDLE, start with command 0 or 1 SHALL latch command, data_ptr, base address and total = ceil(data_size_bytes/BPB) beats, then go to ADDR; other commands, and start outside IDLE, SHALL be ignored.
REQ-009 If total == 0, the block SHALL return to IDLE the cycle after start with no AXI activity.
REQ-010 In ADDR, axi_awvalid SHALL be 1 with awlen = min(remaining, BURST_BEATS)-1 and awaddr = data_ptr + beats_sent*BPB; on the awready handshake the FSM SHALL go to DATA.
REQ-011 In DATA, W beats SHALL transfer on wvalid&wready; axi_wlast SHALL be 1 on beat awlen; after the last beat the FSM SHALL go to RESP.
REQ-012 In RESP, axi_bready SHALL be 1; on bvalid the FSM SHALL go to ADDR if beats remain, else to IDLE; bresp is not checked. Only one burst SHALL be outstanding at a time.
REQ-013 Stream source: axi_wdata = s_axis_tdata, axi_wvalid = s_axis_tvalid, s_axis_tready = axi_wready, all gated by state == DATA; s_axis_tready SHALL be 0 otherwise.
REQ-014 BRAM source: reads SHALL be issued at consecutive addresses base, base+1, ...; BRAM reads SHALL be issued only in ADDR and DATA states; a read-data FIFO of depth BRAM_DELAY+2 SHALL feed W; bram_rd_en SHALL assert only when FIFO count + reads in flight < depth and reads issued < beats of the current burst; axi_wvalid = FIFO not empty in DATA.
REQ-015 BRAM data SHALL be written to AXI in read order without loss or duplication under arbitrary wready back-pressure.
REQ-016 data_ptr SHALL be BURST_BEATS*BPB aligned (caller responsibility, so no burst crosses 4 KB); the low log2(BPB) bits SHALL be ignored.
REQ-017 The beat counter SHALL be AXI_XFER_SIZE_WIDTH bits wide; the final burst SHALL carry the remainder beats.

Reset
REQ-018 While rst_n == 0: state = IDLE, FIFO empty, counters 0; awvalid, wvalid, wlast, bready, bram_rd_en, s_axis_tready = 0; awaddr, awlen, bram_rd_addr, wdata = 0 (wdata in stream mode = gated 0); o_axi_wr_done = 1.
REQ-019 Reset asserted mid-transfer SHALL abort immediately with no further AXI or BRAM activity after deassertion until a new start.

Verification
REQ-020 cmd 0, size 4096, BURST_BEATS 16, wready always 1 -> four bursts, awlen 15, awaddr +1024 each, 64 beats equal to BRAM words base..base+63, done high after fourth B.
REQ-021 cmd 0, size 100 -> one burst awlen 1, two beats, wlast on beat 2.
REQ-022 cmd 1, size 2048, random tvalid/wready -> two bursts, the W beat sequence equals the tdata sequence, tready low outside DATA.
REQ-023 cmd 0, wready random 30%, BRAM_DELAY 3 -> no FIFO overflow, data order preserved, bram_rd_en never exceeds FIFO credits.
REQ-024 size 0 start -> done low for one cycle, no awvalid; start with cmd 2 -> no state change.
REQ-025 rst_n pulsed low during DATA -> all outputs at reset values, next start completes a full correct transfer.

Source files
------------

// File: rtl/axi_data_wr_top.sv
// AXI4 write master: moves a byte-sized transfer from BRAM or an AXI-Stream
// source into AXI memory as BURST_BEATS-sized bursts, one burst outstanding.
module axi_data_wr_top #(
  parameter int unsigned AXI_ADDR_WIDTH      = 64,
  parameter int unsigned AXI_DATA_WIDTH      = 512,
  parameter int unsigned AXI_XFER_SIZE_WIDTH = 32,
  parameter int unsigned BURST_BEATS         = 16,
  parameter int unsigned BRAM_DELAY          = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // AXI write address channel
  output logic                           axi_awvalid,
  input  logic                           axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]      axi_awaddr,
  output logic [7:0]                     axi_awlen,
  // AXI write data channel
  output logic                           axi_wvalid,
  input  logic                           axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]      axi_wdata,
  output logic                           axi_wlast,
  // AXI write response channel
  input  logic                           axi_bvalid,
  output logic                           axi_bready,
  // command interface
  input  logic [31:0]                    i_axi_wr_command,
  input  logic                           i_axi_wr_start,
  output logic                           o_axi_wr_done,
  input  logic [AXI_ADDR_WIDTH-1:0]      i_axi_wr_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]      data_ptr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] data_size_bytes,
  // BRAM read port
  output logic                           bram_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]      bram_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]      bram_rd_data,
  // decoder stream source
  input  logic [AXI_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast
);

  localparam int unsigned AW    = AXI_ADDR_WIDTH;
  localparam int unsigned DW    = AXI_DATA_WIDTH;
  localparam int unsigned XW    = AXI_XFER_SIZE_WIDTH;
  localparam int unsigned BPB   = DW / 8;
  localparam int unsigned LG    = $clog2(BPB);
  localparam int unsigned DEPTH = BRAM_DELAY + 2;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            cmd_q, cmd_d;            // 1 = stream source, 0 = BRAM source
  logic [AW-1:0]   ptr_q, ptr_d;            // beat-aligned destination base
  logic [AW-1:0]   rd_addr_q, rd_addr_d;    // next BRAM word to read
  logic [XW-1:0]   total_q, total_d;        // beats in the whole transfer
  logic [XW-1:0]   sent_q, sent_d;          // beats accepted on W so far
  logic [7:0]      len_q, len_d;            // awlen of the burst in flight
  logic [7:0]      beat_q, beat_d;          // beat index inside the burst
  logic [8:0]      rd_iss_q, rd_iss_d;      // BRAM reads issued for this burst
  logic [BRAM_DELAY-1:0] pipe_q, pipe_d;    // BRAM reads in flight
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic [XW-1:0]   remaining_c;
  logic [8:0]      cur_len_c;
  logic [8:0]      rd_lim_c;
  logic [XW-1:0]   size_beats_c;
  logic [CW:0]     credit_used_c;
  logic            fifo_push_c;
  logic            fifo_pop_c;
  logic            w_fire_c;
  logic            cmd_ok_c;
  logic            in_data_c;
  logic            unused_ok;

  assign unused_ok = ^{s_axis_tlast, data_ptr[LG-1:0]};

  // Burst sizing and FIFO credit arithmetic
  assign remaining_c   = total_q - sent_q;
  assign cur_len_c     = (remaining_c > XW'(BURST_BEATS)) ? 9'(BURST_BEATS) : 9'(remaining_c);
  assign rd_lim_c      = (state_q == S_ADDR) ? cur_len_c : ({1'b0, len_q} + 9'd1);
  assign size_beats_c  = XW'(data_size_bytes >> LG) + XW'(|data_size_bytes[LG-1:0]);
  assign credit_used_c = (CW+1)'(cnt_q) + (CW+1)'($countones(pipe_q));
  assign cmd_ok_c      = (i_axi_wr_command == 32'd0) || (i_axi_wr_command == 32'd1);
  assign in_data_c     = (state_q == S_DATA);

  // Channel outputs derived from registered state, gated by FSM state
  assign o_axi_wr_done = (state_q == S_IDLE);
  assign axi_awvalid   = (state_q == S_ADDR) && (remaining_c != '0);
  assign axi_awaddr    = axi_awvalid ? (ptr_q + (AW'(sent_q) << LG)) : '0;
  assign axi_awlen     = axi_awvalid ? 8'(cur_len_c - 9'd1) : '0;
  assign axi_bready    = (state_q == S_RESP);
  assign axi_wvalid    = in_data_c && (cmd_q ? s_axis_tvalid : (cnt_q != '0));
  assign axi_wlast     = in_data_c && (beat_q == len_q);
  assign axi_wdata     = in_data_c ? (cmd_q ? s_axis_tdata : mem_q[rd_ptr_q]) : '0;
  assign s_axis_tready = in_data_c && cmd_q && axi_wready;
  assign bram_rd_en    = !cmd_q && ((state_q == S_ADDR) || in_data_c) &&
                         (rd_iss_q < rd_lim_c) && (credit_used_c < (CW+1)'(DEPTH));
  assign bram_rd_addr  = rd_addr_q;

  assign w_fire_c    = axi_wvalid && axi_wready;
  assign fifo_pop_c  = w_fire_c && !cmd_q;
  assign fifo_push_c = pipe_q[BRAM_DELAY-1];

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= 1'b0;
      ptr_q     <= '0;
      rd_addr_q <= '0;
      total_q   <= '0;
      sent_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      rd_iss_q  <= '0;
      pipe_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      ptr_q     <= ptr_d;
      rd_addr_q <= rd_addr_d;
      total_q   <= total_d;
      sent_q    <= sent_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      rd_iss_q  <= rd_iss_d;
      pipe_q    <= pipe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Read-data FIFO storage, filled when a BRAM read matures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (fifo_push_c) begin
      mem_q[wr_ptr_q] <= bram_rd_data;
    end
  end

  // Next-state: FSM transitions, beat/read bookkeeping and FIFO pointers
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    rd_addr_d = rd_addr_q;
    total_d   = total_q;
    sent_d    = sent_q;
    len_d     = len_q;
    beat_d    = beat_q;
    rd_iss_d  = rd_iss_q;
    pipe_d    = BRAM_DELAY'({pipe_q, bram_rd_en});
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_axi_wr_start && cmd_ok_c) begin
          cmd_d     = i_axi_wr_command[0];
          ptr_d     = {data_ptr[AW-1:LG], LG'(0)};
          rd_addr_d = i_axi_wr_base_addr;
          total_d   = size_beats_c;
          sent_d    = '0;
          rd_iss_d  = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (remaining_c == '0) begin
          state_d = S_IDLE;
        end else if (axi_awready) begin
          len_d   = axi_awlen;
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire_c) begin
          sent_d = sent_q + XW'(1);
          beat_d = beat_q + 8'd1;
          if (axi_wlast) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (axi_bvalid) begin
          if (remaining_c != '0) begin
            rd_iss_d = '0;
            state_d  = S_ADDR;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // BRAM reads only happen in ADDR/DATA, where rd_iss is never cleared
    if (bram_rd_en) begin
      rd_iss_d  = rd_iss_q + 9'd1;
      rd_addr_d = rd_addr_q + AW'(1);
    end

    if (fifo_push_c) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_pop_c)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (fifo_push_c && !fifo_pop_c)      cnt_d = cnt_q + CW'(1);
    else if (fifo_pop_c && !fifo_push_c) cnt_d = cnt_q - CW'(1);
  end

endmodule

// File: tb/tb_axi_data_wr_top.sv
// Self-checking bench for axi_data_wr_top: random AXI slave / BRAM / stream
// environment, transfer-level reference model, directed scenario sequence.
module tb_axi_data_wr_top;

  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 512;
  localparam int unsigned XW    = 32;
  localparam int unsigned BB    = 16;
  localparam int unsigned BD    = 3;
  localparam int unsigned BPB   = DW / 8;
  localparam int unsigned DEPTH = BD + 2;

  logic          clk, rst_n;
  logic          axi_awvalid, axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_wvalid, axi_wready, axi_wlast;
  logic [DW-1:0] axi_wdata;
  logic          axi_bvalid, axi_bready;
  logic [31:0]   cmd;
  logic          start, done;
  logic [AW-1:0] base_addr, ptr;
  logic [XW-1:0] size;
  logic          bram_rd_en;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;

  axi_data_wr_top #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_XFER_SIZE_WIDTH(XW),
    .BURST_BEATS(BB), .BRAM_DELAY(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .i_axi_wr_command(cmd), .i_axi_wr_start(start), .o_axi_wr_done(done),
    .i_axi_wr_base_addr(base_addr), .data_ptr(ptr), .data_size_bytes(size),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // environment knobs (percent probabilities) and monitor state
  int aw_pct = 100, w_pct = 100, tv_pct = 100, b_pct = 100;
  bit mode_stream = 1'b0;
  logic [DW-1:0] stream_mem [$];
  int s_idx = 0;
  logic [AW-1:0] aw_addr_q [$];
  logic [7:0]    aw_len_q  [$];
  logic [DW-1:0] w_data_q  [$];
  bit            w_last_q  [$];
  int aw_cnt = 0, b_cnt = 0, w_cnt = 0, rd_cnt = 0, b_pend = 0, activity = 0;
  int viol_rdaddr = 0, viol_credit = 0, viol_tready = 0, viol_outst = 0, viol_rdstate = 0;
  logic [AW-1:0] rd_exp = '0;
  bit b_acc = 1'b0;
  logic pend_en = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] dpipe [BD];

  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = (32'(a) * 32'h9E37_79B1 + 32'(k)) ^ 32'h5A5A_0000;
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // AXI slave, BRAM model, stream source and protocol monitors
  initial begin
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    bram_rd_data = '0;
    for (int i = 0; i < int'(BD); i++) dpipe[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_pend = 0; b_acc = 1'b0; pend_en = 1'b0;
      end else begin
        if (axi_awvalid || axi_wvalid || bram_rd_en) activity++;
        if (axi_awvalid && axi_awready) begin
          if (aw_cnt != b_cnt) viol_outst++;
          aw_addr_q.push_back(axi_awaddr);
          aw_len_q.push_back(axi_awlen);
          aw_cnt++;
        end
        if (bram_rd_en) begin
          if (bram_rd_addr !== rd_exp) viol_rdaddr++;
          if (rd_cnt - w_cnt >= int'(DEPTH)) viol_credit++;
          if (mode_stream || axi_bready || done) viol_rdstate++;
          rd_exp = rd_exp + 1;
          rd_cnt++;
        end
        pend_en = bram_rd_en;
        pend_addr = bram_rd_addr;
        if (s_axis_tready && (!mode_stream || axi_awvalid || axi_bready || done)) viol_tready++;
        if (axi_wvalid && axi_wready) begin
          w_data_q.push_back(axi_wdata);
          w_last_q.push_back(axi_wlast);
          w_cnt++;
          if (axi_wlast) b_pend++;
        end
        if (s_axis_tvalid && s_axis_tready) s_idx++;
        b_acc = axi_bvalid && axi_bready;
        if (b_acc) begin b_pend--; b_cnt++; end
      end
      @(posedge clk);
      #1;
      for (int i = int'(BD) - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
      dpipe[0] = pend_en ? bram_word(pend_addr) : rand_word();
      pend_en = 1'b0;
      bram_rd_data = dpipe[BD-1];
      axi_awready = ($urandom_range(0, 99) < aw_pct);
      axi_wready  = ($urandom_range(0, 99) < w_pct);
      s_axis_tvalid = (s_idx < stream_mem.size()) && ($urandom_range(0, 99) < tv_pct);
      s_axis_tdata  = s_axis_tvalid ? stream_mem[s_idx] : rand_word();
      s_axis_tlast  = $urandom_range(0, 1) == 1;
      if (!rst_n) axi_bvalid = 1'b0;
      else if (!(axi_bvalid && !b_acc)) axi_bvalid = (b_pend > 0) && ($urandom_range(0, 99) < b_pct);
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input logic [AW-1:0] base);
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
    aw_cnt = 0; b_cnt = 0; w_cnt = 0; rd_cnt = 0; activity = 0; s_idx = 0;
    viol_rdaddr = 0; viol_credit = 0; viol_tready = 0; viol_outst = 0; viol_rdstate = 0;
    rd_exp = base;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " awvalid"}, DW'(axi_awvalid), '0);
    chk({tag, " wvalid"},  DW'(axi_wvalid), '0);
    chk({tag, " wlast"},   DW'(axi_wlast), '0);
    chk({tag, " bready"},  DW'(axi_bready), '0);
    chk({tag, " rd_en"},   DW'(bram_rd_en), '0);
    chk({tag, " tready"},  DW'(s_axis_tready), '0);
    chk({tag, " awaddr"},  DW'(axi_awaddr), '0);
    chk({tag, " awlen"},   DW'(axi_awlen), '0);
    chk({tag, " rd_addr"}, DW'(bram_rd_addr), '0);
    chk({tag, " wdata"},   axi_wdata, '0);
    chk({tag, " done"},    DW'(done), DW'(1));
  endtask

  task automatic pulse_start(input int c, input int sz, input logic [AW-1:0] p, input logic [AW-1:0] b);
    @(posedge clk); #1;
    cmd = 32'(c); size = XW'(sz); ptr = p; base_addr = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full transfer against the transfer-level model: bursts, beats, data, wlast
  task automatic run_xfer(input string tag, input int c, input int sz, input logic [AW-1:0] p,
                          input logic [AW-1:0] b, input int wp, input int tp, input int ap, input int bp);
    int beats, sent, bi, len, cyc, bad_data, bad_last, expected_bursts;
    logic [AW-1:0] p_al;
    logic [DW-1:0] exp_w;
    bit exp_last;
    w_pct = wp; tv_pct = tp; aw_pct = ap; b_pct = bp;
    mode_stream = (c == 1);
    beats = (sz + int'(BPB) - 1) / int'(BPB);
    stream_mem.delete();
    clear_mon(b);
    if (c == 1) for (int i = 0; i < beats; i++) stream_mem.push_back(rand_word());
    pulse_start(c, sz, p, b);
    cyc = 0;
    do begin @(negedge clk); #1; cyc++; end while (!done && cyc < 20000);
    chk({tag, " completes"}, DW'(cyc < 20000), DW'(1));
    p_al = p & ~AW'(BPB - 1);
    sent = 0; bi = 0;
    while (sent < beats) begin
      len = (beats - sent > int'(BB)) ? int'(BB) : beats - sent;
      if (bi < aw_addr_q.size()) begin
        chk($sformatf("%s awaddr[%0d]", tag, bi), DW'(aw_addr_q[bi]), DW'(p_al + AW'(sent * int'(BPB))));
        chk($sformatf("%s awlen[%0d]", tag, bi), DW'(aw_len_q[bi]), DW'(len - 1));
      end
      sent += len; bi++;
    end
    expected_bursts = bi;
    chk({tag, " bursts"}, DW'(aw_addr_q.size()), DW'(expected_bursts));
    chk({tag, " bresp count"}, DW'(b_cnt), DW'(expected_bursts));
    chk({tag, " beats"}, DW'(w_data_q.size()), DW'(beats));
    bad_data = 0; bad_last = 0;
    for (int i = 0; i < w_data_q.size(); i++) begin
      exp_w = (c == 1) ? stream_mem[i] : bram_word(b + AW'(i));
      exp_last = (((i + 1) % int'(BB)) == 0) || (i == beats - 1);
      if (w_data_q[i] !== exp_w) bad_data++;
      if (w_last_q[i] !== exp_last) bad_last++;
    end
    chk({tag, " data mismatches"}, DW'(bad_data), '0);
    chk({tag, " wlast mismatches"}, DW'(bad_last), '0);
    chk({tag, " rd addr order"}, DW'(viol_rdaddr), '0);
    chk({tag, " fifo credits"}, DW'(viol_credit), '0);
    chk({tag, " rd state"}, DW'(viol_rdstate), '0);
    chk({tag, " tready gating"}, DW'(viol_tready), '0);
    chk({tag, " one outstanding"}, DW'(viol_outst), '0);
    if (c == 0) chk({tag, " reads issued"}, DW'(rd_cnt), DW'(beats));
  endtask

  initial begin
    int cyc, act0, rc, rs;
    rst_n = 1'b0; start = 1'b0; cmd = '0; size = '0; ptr = '0; base_addr = '0;

    // reset values while rst_n is held low
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // four full bursts from BRAM, no back-pressure
    run_xfer("bram4096", 0, 4096, 64'h0000_0001_0000_0000, 64'h100, 100, 100, 100, 100);
    // single short burst: 100 bytes -> 2 beats
    run_xfer("bram100", 0, 100, 64'h0000_0000_2000_0400, 64'h7, 100, 100, 100, 100);
    // stream source, random valid/ready, low pointer bits must be ignored
    run_xfer("stream2048", 1, 2048, 64'h0000_0000_3000_002A, 64'h0, 60, 50, 70, 40);
    // BRAM source under heavy wready back-pressure with remainder burst
    run_xfer("bram_bp30", 0, 3000, 64'h0000_0000_4000_0800, 64'h55, 30, 100, 60, 50);

    // random transfers
    for (int t = 0; t < 4; t++) begin
      rc = $urandom_range(0, 1);
      rs = $urandom_range(1, 3000);
      run_xfer($sformatf("rand%0d", t), rc, rs, AW'({$urandom_range(0, 1023), 10'h0}),
               AW'($urandom_range(0, 4095)), $urandom_range(20, 100),
               $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100));
    end

    // zero-size start: one cycle busy, no AXI/BRAM activity
    clear_mon('0);
    mode_stream = 1'b0;
    pulse_start(0, 0, 64'h5000_0000, 64'h10);
    act0 = activity;
    @(negedge clk); #1;
    chk("size0 done low", DW'(done), '0);
    @(negedge clk); #1;
    chk("size0 done back", DW'(done), DW'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("size0 no activity", DW'(activity - act0), '0);

    // unsupported command is ignored
    pulse_start(2, 1000, 64'h5000_0000, 64'h10);
    @(negedge clk); #1;
    chk("cmd2 done stays", DW'(done), DW'(1));
    repeat (5) @(negedge clk);
    #1;
    chk("cmd2 no activity", DW'(activity - act0), '0);
    chk("cmd2 still idle", DW'(done), DW'(1));

    // reset in the middle of a BRAM transfer
    w_pct = 100; aw_pct = 100; b_pct = 100; mode_stream = 1'b0;
    stream_mem.delete();
    clear_mon(64'h200);
    pulse_start(0, 4096, 64'h6000_0000, 64'h200);
    cyc = 0;
    do begin @(negedge clk); #1; cyc++; end while (w_cnt < 5 && cyc < 2000);
    chk("midreset reached data", DW'(cyc < 2000), DW'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon('0);
    repeat (20) @(negedge clk);
    #1;
    chk("post-reset quiet", DW'(activity), '0);
    chk("post-reset done", DW'(done), DW'(1));
    run_xfer("after_reset", 0, 4096, 64'h6000_0000, 64'h200, 70, 100, 80, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
